// File: rtl/vx_issue_scoreboard_if.sv
// Issue-slice bundle: instruction-buffer head, issued-instruction output, writeback events and stall counter.
// master = instruction-buffer/writeback side, slave = scoreboard.
interface vx_issue_scoreboard_if #(
    parameter int DATAW     = 128,
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64
);
    localparam int ISSUE_WIS_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NR_BITS     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                   ibuf_valid;
    logic                   ibuf_ready;
    logic [DATAW-1:0]       ibuf_data;
    logic [ISSUE_WIS_W-1:0] ibuf_wis;
    logic                   ibuf_wb;
    logic [NR_BITS-1:0]     ibuf_rd;
    logic [NR_BITS-1:0]     ibuf_rs1;
    logic [NR_BITS-1:0]     ibuf_rs2;
    logic [NR_BITS-1:0]     ibuf_rs3;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATAW-1:0]       out_data;
    logic [ISSUE_WIS_W-1:0] out_wis;

    logic                   wb_valid;
    logic [ISSUE_WIS_W-1:0] wb_wis;
    logic [NR_BITS-1:0]     wb_rd;
    logic                   wb_eop;

    logic [31:0]            perf_stalls;

    modport master (
        output ibuf_valid, ibuf_data, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
        output out_ready,
        output wb_valid, wb_wis, wb_rd, wb_eop,
        input  ibuf_ready, out_valid, out_data, out_wis, perf_stalls
    );

    modport slave (
        input  ibuf_valid, ibuf_data, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
        input  out_ready,
        input  wb_valid, wb_wis, wb_rd, wb_eop,
        output ibuf_ready, out_valid, out_data, out_wis, perf_stalls
    );
endinterface

// File: rtl/vx_issue_scoreboard.sv
// Per-warp register scoreboard: holds the ibuf head until its registers are free, issues via a 1-entry output reg (1 cycle).
// Head is held while hazarded or output busy; SCOREBOARD_BYPASS_EN lets a same-cycle writeback clear unblock issue.
module vx_issue_scoreboard #(
    parameter int DATAW     = 128,
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_issue_scoreboard_if.slave  sb
);
    localparam int ISSUE_WIS_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_vis;
    logic                   out_valid_q, out_valid_d;
    logic [DATAW-1:0]       out_data_q, out_data_d;
    logic [ISSUE_WIS_W-1:0] out_wis_q, out_wis_d;
    logic [31:0]            perf_stalls_q, perf_stalls_d;

    logic wb_clr;
    logic hazard;
    logic accept;

    assign wb_clr = sb.wb_valid && sb.wb_eop;

    // Table as seen by the hazard check; r0 is never set, so it can never hazard.
    always_comb begin
        pending_vis = pending_q;
`ifdef SCOREBOARD_BYPASS_EN
        if (wb_clr) begin
            pending_vis[sb.wb_wis][sb.wb_rd] = 1'b0;
        end
`endif
    end

    assign hazard = sb.ibuf_valid &&
                    (pending_vis[sb.ibuf_wis][sb.ibuf_rs1] ||
                     pending_vis[sb.ibuf_wis][sb.ibuf_rs2] ||
                     pending_vis[sb.ibuf_wis][sb.ibuf_rs3] ||
                     (sb.ibuf_wb && pending_vis[sb.ibuf_wis][sb.ibuf_rd]));

    assign sb.ibuf_ready = !hazard && (!out_valid_q || sb.out_ready);
    assign accept        = sb.ibuf_valid && sb.ibuf_ready;

    always_comb begin
        pending_d     = pending_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_wis_d     = out_wis_q;
        perf_stalls_d = perf_stalls_q;

        // Clear first so a same-entry set in this cycle overrides it.
        if (wb_clr) begin
            pending_d[sb.wb_wis][sb.wb_rd] = 1'b0;
        end
        if (accept && sb.ibuf_wb && (sb.ibuf_rd != '0)) begin
            pending_d[sb.ibuf_wis][sb.ibuf_rd] = 1'b1;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sb.ibuf_data;
            out_wis_d   = sb.ibuf_wis;
        end else if (sb.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (hazard && (perf_stalls_q != 32'hFFFF_FFFF)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q     <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_wis_q     <= '0;
            perf_stalls_q <= '0;
        end else begin
            pending_q     <= pending_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_wis_q     <= out_wis_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign sb.out_valid   = out_valid_q;
    assign sb.out_data    = out_data_q;
    assign sb.out_wis     = out_wis_q;
    assign sb.perf_stalls = perf_stalls_q;
endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Directed-vector bench for vx_issue_scoreboard; expectations follow SCOREBOARD_BYPASS_EN when defined.
module tb_vx_issue_scoreboard;
    localparam int DATAW     = 128;
    localparam int NUM_WARPS = 4;
    localparam int NUM_REGS  = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_issue_scoreboard_if #(.DATAW(DATAW), .NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS)) sb_if ();

    vx_issue_scoreboard #(.DATAW(DATAW), .NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_stalls;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pay(input int w, input int r);
        return {96'h0, 8'(w), 8'hA5, 16'(r)};
    endfunction

    task automatic ibuf_idle();
        sb_if.ibuf_valid = 1'b0;
        sb_if.ibuf_data  = '0;
        sb_if.ibuf_wis   = '0;
        sb_if.ibuf_wb    = 1'b0;
        sb_if.ibuf_rd    = '0;
        sb_if.ibuf_rs1   = '0;
        sb_if.ibuf_rs2   = '0;
        sb_if.ibuf_rs3   = '0;
    endtask

    task automatic issue_in(input int w, input logic wb, input int rd,
                            input int rs1, input int rs2, input int rs3, input logic [127:0] d);
        sb_if.ibuf_valid = 1'b1;
        sb_if.ibuf_data  = d;
        sb_if.ibuf_wis   = 2'(w);
        sb_if.ibuf_wb    = wb;
        sb_if.ibuf_rd    = 6'(rd);
        sb_if.ibuf_rs1   = 6'(rs1);
        sb_if.ibuf_rs2   = 6'(rs2);
        sb_if.ibuf_rs3   = 6'(rs3);
    endtask

    task automatic wb_set(input logic v, input logic eop, input int w, input int rd);
        sb_if.wb_valid = v;
        sb_if.wb_eop   = eop;
        sb_if.wb_wis   = 2'(w);
        sb_if.wb_rd    = 6'(rd);
    endtask

    // Presents a head for 1 ns between edges and withdraws it, so nothing is accepted or counted.
    task automatic probe(input string tag, input int w, input int rs1, input int rs2, input int rs3,
                         input logic wb, input int rd, input logic exp);
        @(negedge clk);
        issue_in(w, wb, rd, rs1, rs2, rs3, '0);
        #1 check_eq(tag, sb_if.ibuf_ready, exp);
        ibuf_idle();
    endtask

    initial begin
        reset = 1'b0;
        ibuf_idle();
        wb_set(1'b0, 1'b0, 0, 0);
        sb_if.out_ready = 1'b1;
        exp_stalls = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", sb_if.out_valid, 1'b0);
        check_eq("rst_out_data", sb_if.out_data, '0);
        check_eq("rst_out_wis", sb_if.out_wis, '0);
        check_eq("rst_perf", sb_if.perf_stalls, 32'd0);
        @(negedge clk) reset = 1'b1;
        #1 check_eq("rst_ibuf_ready", sb_if.ibuf_ready, 1'b1);

        // Independent stream, warp 0, rd = 1..4
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            issue_in(0, 1'b1, i, 0, 0, 0, pay(0, i));
            #1 check_eq("stream_ready", sb_if.ibuf_ready, 1'b1);
            @(posedge clk);
            #1;
            check_eq("stream_out_valid", sb_if.out_valid, 1'b1);
            check_eq("stream_out_data", sb_if.out_data, pay(0, i));
        end
        @(negedge clk) ibuf_idle();
        @(posedge clk);
        #1;
        check_eq("stream_drain", sb_if.out_valid, 1'b0);
        check_eq("stream_perf", sb_if.perf_stalls, exp_stalls);
        for (int k = 1; k <= 4; k++) probe("stream_pending", 0, k, 0, 0, 1'b0, 0, 1'b0);
        probe("other_warp_free", 1, 1, 0, 0, 1'b0, 0, 1'b1);

        // RAW on warp 1, r5
        @(negedge clk);
        issue_in(1, 1'b1, 5, 0, 0, 0, pay(1, 5));
        @(posedge clk);
        #1 check_eq("raw_producer", sb_if.out_data, pay(1, 5));
        @(negedge clk);
        issue_in(1, 1'b1, 6, 5, 0, 0, pay(1, 6));
        for (int j = 0; j < 3; j++) begin
            #1 check_eq("raw_stall", sb_if.ibuf_ready, 1'b0);
            @(posedge clk);
            exp_stalls++;
            @(negedge clk);
        end
        wb_set(1'b1, 1'b1, 1, 5);
`ifdef SCOREBOARD_BYPASS_EN
        #1 check_eq("raw_wb_cycle_ready", sb_if.ibuf_ready, 1'b1);
        @(posedge clk);
        #1;
`else
        #1 check_eq("raw_wb_cycle_ready", sb_if.ibuf_ready, 1'b0);
        @(posedge clk);
        exp_stalls++;
        @(negedge clk);
        wb_set(1'b0, 1'b0, 0, 0);
        #1 check_eq("raw_after_wb_ready", sb_if.ibuf_ready, 1'b1);
        @(posedge clk);
        #1;
`endif
        check_eq("raw_issue_data", sb_if.out_data, pay(1, 6));
        check_eq("raw_issue_wis", sb_if.out_wis, 2'd1);
        check_eq("raw_perf", sb_if.perf_stalls, exp_stalls);
        @(negedge clk);
        ibuf_idle();
        wb_set(1'b0, 1'b0, 0, 0);

        // Cross-warp: warp 2 owns r7, warp 3 reads r7
        @(negedge clk);
        issue_in(2, 1'b1, 7, 0, 0, 0, pay(2, 7));
        @(negedge clk);
        issue_in(3, 1'b0, 0, 7, 0, 0, pay(3, 7));
        #1 check_eq("cross_ready", sb_if.ibuf_ready, 1'b1);
        @(posedge clk);
        #1 check_eq("cross_wis", sb_if.out_wis, 2'd3);
        @(negedge clk) ibuf_idle();
        probe("cross_w2_pending", 2, 0, 7, 0, 1'b0, 0, 1'b0);

        // Non-eop writeback leaves r3 pending; eop clears it
        @(negedge clk) wb_set(1'b1, 1'b0, 0, 3);
        @(negedge clk) wb_set(1'b0, 1'b0, 0, 0);
        probe("noeop_pending", 0, 3, 0, 0, 1'b0, 0, 1'b0);
        @(negedge clk) wb_set(1'b1, 1'b1, 0, 3);
        @(negedge clk) wb_set(1'b0, 1'b0, 0, 0);
        probe("eop_cleared", 0, 3, 0, 0, 1'b0, 0, 1'b1);

        // Same-entry set and clear: set wins
        @(negedge clk);
        issue_in(0, 1'b1, 9, 0, 0, 0, pay(0, 9));
        wb_set(1'b1, 1'b1, 0, 9);
        @(posedge clk);
        #1 check_eq("setwins_issue", sb_if.out_data, pay(0, 9));
        @(negedge clk);
        ibuf_idle();
        wb_set(1'b0, 1'b0, 0, 0);
        probe("setwins_pending", 0, 9, 0, 0, 1'b0, 0, 1'b0);

        // r0 is never pending; rs3 and WAW hazards are seen
        @(negedge clk) issue_in(0, 1'b1, 0, 0, 0, 0, pay(0, 0));
        @(negedge clk) ibuf_idle();
        probe("r0_free", 0, 0, 0, 0, 1'b1, 0, 1'b1);
        probe("rs3_hazard", 0, 0, 0, 2, 1'b0, 0, 1'b0);
        probe("waw_hazard", 0, 0, 0, 0, 1'b1, 1, 1'b0);
        check_eq("probe_perf", sb_if.perf_stalls, exp_stalls);

        // Backpressure
        @(negedge clk);
        sb_if.out_ready = 1'b0;
        issue_in(3, 1'b1, 10, 0, 0, 0, pay(3, 10));
        #1 check_eq("bp_first_ready", sb_if.ibuf_ready, 1'b1);
        @(posedge clk);
        #1 check_eq("bp_first_data", sb_if.out_data, pay(3, 10));
        @(negedge clk);
        issue_in(3, 1'b0, 0, 0, 0, 0, pay(3, 11));
        for (int j = 0; j < 3; j++) begin
            #1 check_eq("bp_ready", sb_if.ibuf_ready, 1'b0);
            @(posedge clk);
            #1;
            check_eq("bp_valid", sb_if.out_valid, 1'b1);
            check_eq("bp_data_stable", sb_if.out_data, pay(3, 10));
            check_eq("bp_wis_stable", sb_if.out_wis, 2'd3);
            @(negedge clk);
        end
        check_eq("bp_perf", sb_if.perf_stalls, exp_stalls);
        sb_if.out_ready = 1'b1;
        #1 check_eq("bp_release_ready", sb_if.ibuf_ready, 1'b1);
        @(posedge clk);
        #1 check_eq("bp_release_data", sb_if.out_data, pay(3, 11));

        // Reset mid-flight
        @(negedge clk);
        ibuf_idle();
        sb_if.out_ready = 1'b0;
        #1 check_eq("midrst_pre_valid", sb_if.out_valid, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", sb_if.out_valid, 1'b0);
        check_eq("midrst_out_data", sb_if.out_data, '0);
        check_eq("midrst_perf", sb_if.perf_stalls, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        sb_if.out_ready = 1'b1;
        @(negedge clk);
        issue_in(0, 1'b1, 1, 1, 2, 4, pay(0, 20));
        #1 check_eq("midrst_ready", sb_if.ibuf_ready, 1'b1);
        @(posedge clk);
        #1;
        check_eq("midrst_issue_valid", sb_if.out_valid, 1'b1);
        check_eq("midrst_issue_data", sb_if.out_data, pay(0, 20));
        @(negedge clk) ibuf_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
